bus_master_interface: RTL and testbench

BUS_MASTER_INTERFACE -- requirements
Module: bus_master_interface

---
 rtl/bus_pkg.sv | 15 +
 rtl/bus_timeout_counter.sv | 37 +++
 rtl/bus_master_interface.sv | 152 +++++++++++++++
 tb/tb_bus_master_interface.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and widths for the bus master bridge.
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 32;
  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_MASK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_RELEASE = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Cycle counter that flags when a bus transaction has waited TIMEOUT_CYCLES-1 cycles.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == TERM_CNT);

  // Saturate at the terminal count so a stalled enable can never wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_master_interface.sv
// Bus master bridge: turns single core requests into strobed system-bus
// transactions, completed by the slave fc handshake or aborted on timeout.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | bus parked, req_ready=1, waiting for a core request
// ST_READ    | rd_bus asserted, waiting for fc_bus or timeout
// ST_WRITE   | wr_bus asserted and data_bus driven, waiting for fc_bus or timeout
// ST_RELEASE | bus parked, waiting for the slave to drop fc_bus
module bus_master_interface
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [BUS_ADDR_W-1:0] req_addr,
  input  logic [BUS_DATA_W-1:0] req_wdata,
  input  logic [BUS_MASK_W-1:0] req_mask,
  output logic                  resp_valid,
  output logic [BUS_DATA_W-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [BUS_ADDR_W-1:0] addr_bus,
  inout  wire  [BUS_DATA_W-1:0] data_bus,
  output logic                  rd_bus,
  output logic                  wr_bus,
  output logic [BUS_MASK_W-1:0] data_mask_bus,
  input  logic                  fc_bus
);

  bus_state_e state_q, state_d;

  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  drive_q, drive_d;
  logic [BUS_ADDR_W-1:0] addr_bus_q, addr_bus_d;
  logic [BUS_MASK_W-1:0] mask_bus_q, mask_bus_d;
  logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [BUS_DATA_W-1:0] resp_rdata_q, resp_rdata_d;

  logic accept;
  logic busy;
  logic expired;
  logic finish;

  assign accept = (state_q == ST_IDLE) && req_valid;
  assign busy   = (state_q == ST_READ) || (state_q == ST_WRITE);
  // A completion on the terminal-count edge is still a completion.
  assign finish = busy && (fc_bus || expired);

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (busy),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_valid) state_d = req_wr ? ST_WRITE : ST_READ;
      ST_READ,
      ST_WRITE:   if (fc_bus || expired) state_d = ST_RELEASE;
      ST_RELEASE: if (!fc_bus) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == ST_IDLE);
    rd_d         = rd_q;
    wr_d         = wr_q;
    drive_d      = drive_q;
    addr_bus_d   = addr_bus_q;
    mask_bus_d   = mask_bus_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    if (accept) begin
      rd_d       = !req_wr;
      wr_d       = req_wr;
      drive_d    = req_wr;
      addr_bus_d = req_addr;
      mask_bus_d = req_mask;
      wdata_d    = req_wdata;
    end else if (finish || !busy) begin
      rd_d       = 1'b0;
      wr_d       = 1'b0;
      drive_d    = 1'b0;
      addr_bus_d = '0;
      mask_bus_d = '0;
    end
    if (finish) begin
      resp_valid_d = 1'b1;
      resp_err_d   = !fc_bus;
      if ((state_q == ST_READ) && fc_bus) begin
        resp_rdata_d = data_bus;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      drive_q      <= 1'b0;
      addr_bus_q   <= '0;
      mask_bus_q   <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      drive_q      <= drive_d;
      addr_bus_q   <= addr_bus_d;
      mask_bus_q   <= mask_bus_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign rd_bus        = rd_q;
  assign wr_bus        = wr_q;
  assign addr_bus      = addr_bus_q;
  assign data_mask_bus = mask_bus_q;
  assign data_bus      = drive_q ? wdata_q : {BUS_DATA_W{1'bz}};
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;

endmodule

// File: tb/tb_bus_master_interface.sv
// Directed bench for bus_master_interface: vector table plus handshake/reset sequences.
module tb_bus_master_interface;

  localparam logic [31:0] PROBE = 32'h1234_5670;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] addr_bus;
  wire  [31:0] data_bus;
  logic        rd_bus;
  logic        wr_bus;
  logic [3:0]  data_mask_bus;
  logic        fc_bus;

  // Slave / probe driver: drives read data, or a probe word whenever the DUT must be high-Z.
  logic        tb_drv_en;
  logic [31:0] tb_drv_val;
  assign data_bus = tb_drv_en ? tb_drv_val : 32'hzzzz_zzzz;

  bus_master_interface #(.TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_mask     (req_mask),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .addr_bus     (addr_bus),
    .data_bus     (data_bus),
    .rd_bus       (rd_bus),
    .wr_bus       (wr_bus),
    .data_mask_bus(data_mask_bus),
    .fc_bus       (fc_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Longest run of consecutive resp_valid cycles.
  int rv_run = 0;
  int rv_max = 0;
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      rv_run = rv_run + 1;
      if (rv_run > rv_max) rv_max = rv_run;
    end else begin
      rv_run = 0;
    end
  end

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    int          fc_at;       // strobe cycle in which the slave raises fc (0 = never)
    logic [31:0] slave_data;
    int          exp_strobes;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int          strobes;
    int          hold_err;
    logic        got_resp;
    logic [31:0] r_data;
    logic        r_err;
    logic [31:0] rel_bus;
    strobes  = 0;
    hold_err = 0;
    got_resp = 1'b0;
    r_data   = '0;
    r_err    = 1'b0;
    rel_bus  = '0;
    @(negedge clk);
    chk({v.name, "_ready"}, req_ready, 1);
    req_valid  = 1'b1;
    req_wr     = v.wr;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_mask   = v.mask;
    tb_drv_en  = ~v.wr;
    tb_drv_val = v.slave_data;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 40 && !got_resp; c++) begin
      if (rd_bus || wr_bus) begin
        strobes++;
        if (rd_bus !== ~v.wr || wr_bus !== v.wr || addr_bus !== v.addr ||
            data_mask_bus !== v.mask) hold_err++;
        if (v.wr && data_bus !== v.wdata) hold_err++;
        if (!v.wr && data_bus !== v.slave_data) hold_err++;
      end
      if (resp_valid) begin
        got_resp   = 1'b1;
        r_data     = resp_rdata;
        r_err      = resp_err;
        fc_bus     = 1'b0;
        tb_drv_en  = 1'b1;
        tb_drv_val = PROBE;
        #1;
        rel_bus = data_bus;
        if (rd_bus || wr_bus || addr_bus != 0 || data_mask_bus != 0) hold_err++;
      end else begin
        fc_bus = (c == v.fc_at);
      end
      @(negedge clk);
    end
    chk({v.name, "_got_resp"}, got_resp, 1);
    chk({v.name, "_strobes"}, strobes, v.exp_strobes);
    chk({v.name, "_bus_hold"}, hold_err, 0);
    chk({v.name, "_err"}, r_err, v.exp_err);
    chk({v.name, "_rdata"}, r_data, v.exp_rdata);
    chk({v.name, "_release_hiz"}, rel_bus, PROBE);
    chk({v.name, "_pulse_end"}, resp_valid, 0);
    chk({v.name, "_back_idle"}, req_ready, 1);
    fc_bus = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    int rv_seen;
    vecs[0] = '{"wr_basic",   1'b1, 32'h7000_0008, 32'h0000_000A, 4'b1111, 3,  32'h0,         3,  1'b0, 32'h0};
    vecs[1] = '{"rd_fast",    1'b0, 32'h7000_0004, 32'h0,         4'b1111, 1,  32'hDEAD_BEEF, 1,  1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{"rd_timeout", 1'b0, 32'h7000_0000, 32'h0,         4'b1111, 0,  32'hA5A5_A5A5, 16, 1'b1, 32'h0};
    vecs[3] = '{"wr_mask",    1'b1, 32'h7000_000C, 32'h5555_AAAA, 4'b0011, 2,  32'h0,         2,  1'b0, 32'h0};
    vecs[4] = '{"rd_fc_last", 1'b0, 32'h7000_0010, 32'h0,         4'b0101, 16, 32'h0BAD_F00D, 16, 1'b0, 32'h0BAD_F00D};
    vecs[5] = '{"wr_timeout", 1'b1, 32'h7000_0014, 32'h8765_4321, 4'b1000, 0,  32'h0,         16, 1'b1, 32'h0};
    vecs[6] = '{"rd_mid",     1'b0, 32'h7000_0018, 32'h0,         4'b1111, 5,  32'h00C0_FFEE, 5,  1'b0, 32'h00C0_FFEE};

    rst        = 1'b0;
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_mask   = '0;
    fc_bus     = 1'b0;
    tb_drv_en  = 1'b1;
    tb_drv_val = PROBE;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_strobes", {rd_bus, wr_bus}, 0);
    chk("rst_addr", addr_bus, 0);
    chk("rst_mask", data_mask_bus, 0);
    chk("rst_data_hiz", data_bus, PROBE);

    foreach (vecs[i]) run_vec(vecs[i]);

    // fc held after completion while req_valid stays high
    @(negedge clk);
    req_valid  = 1'b1;
    req_wr     = 1'b0;
    req_addr   = 32'h7000_0030;
    req_mask   = 4'b1111;
    tb_drv_en  = 1'b1;
    tb_drv_val = 32'h1357_2468;
    @(negedge clk);
    chk("hold_rd_strobe", rd_bus, 1);
    fc_bus = 1'b1;
    @(negedge clk);
    chk("hold_resp_valid", resp_valid, 1);
    chk("hold_resp_rdata", resp_rdata, 32'h1357_2468);
    req_wr    = 1'b1;
    req_addr  = 32'h7000_0040;
    req_wdata = 32'h0F0F_0F0F;
    req_mask  = 4'b1100;
    tb_drv_en = 1'b0;
    bad = 0;
    for (int c = 2; c <= 6; c++) begin
      if (req_ready !== 1'b0 || rd_bus || wr_bus) bad++;
      if (c == 6) fc_bus = 1'b0;
      @(negedge clk);
    end
    chk("hold_not_ready", bad, 0);
    chk("hold_idle_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("hold_next_wr", wr_bus, 1);
    chk("hold_next_addr", addr_bus, 32'h7000_0040);
    chk("hold_next_mask", data_mask_bus, 4'b1100);
    chk("hold_next_data", data_bus, 32'h0F0F_0F0F);
    fc_bus = 1'b1;
    @(negedge clk);
    chk("hold_next_resp", {resp_valid, resp_err}, 2'b10);
    chk("hold_next_rdata", resp_rdata, 0);
    fc_bus     = 1'b0;
    tb_drv_en  = 1'b1;
    tb_drv_val = PROBE;
    @(negedge clk);
    chk("hold_next_idle", req_ready, 1);

    // reset in the middle of a write
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 32'h7000_0020;
    req_wdata = 32'hCAFE_F00D;
    req_mask  = 4'b1111;
    tb_drv_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstw_strobe", wr_bus, 1);
    chk("rstw_data", data_bus, 32'hCAFE_F00D);
    @(negedge clk);
    #2;
    rst        = 1'b0;
    tb_drv_en  = 1'b1;
    tb_drv_val = PROBE;
    #1;
    chk("rstw_strobes_drop", {rd_bus, wr_bus}, 0);
    chk("rstw_addr", addr_bus, 0);
    chk("rstw_mask", data_mask_bus, 0);
    chk("rstw_data_hiz", data_bus, PROBE);
    rv_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    chk("rstw_no_resp", rv_seen, 0);
    chk("rstw_ready", req_ready, 1);

    chk("resp_pulse_width", (rv_max == 1), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
